// File: rtl/alu_pkg.sv
// Shared constants, types and helpers for the ALU command sequencer.
package alu_pkg;

  localparam int unsigned NREGS = 8;
  localparam int unsigned RIDX_W = 3;
  localparam int unsigned W = 64;
  localparam int unsigned OP_W = 6;
  localparam int unsigned FLG_W = 7;

  localparam logic [OP_W-1:0] OP_ADD   = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd1;
  localparam logic [OP_W-1:0] OP_MUL   = 6'd2;
  localparam logic [OP_W-1:0] OP_DIV   = 6'd3;
  localparam logic [OP_W-1:0] OP_MOD   = 6'd4;
  localparam logic [OP_W-1:0] OP_AND   = 6'd5;
  localparam logic [OP_W-1:0] OP_OR    = 6'd6;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd7;
  localparam logic [OP_W-1:0] OP_NOT   = 6'd8;
  localparam logic [OP_W-1:0] OP_NAND  = 6'd9;
  localparam logic [OP_W-1:0] OP_NOR   = 6'd10;
  localparam logic [OP_W-1:0] OP_XNOR  = 6'd11;
  localparam logic [OP_W-1:0] OP_SHL   = 6'd12;
  localparam logic [OP_W-1:0] OP_SHR   = 6'd13;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd14;
  localparam logic [OP_W-1:0] OP_ROL   = 6'd15;
  localparam logic [OP_W-1:0] OP_ROR   = 6'd16;
  localparam logic [OP_W-1:0] OP_INC   = 6'd17;
  localparam logic [OP_W-1:0] OP_DEC   = 6'd18;
  localparam logic [OP_W-1:0] OP_NEG   = 6'd19;
  localparam logic [OP_W-1:0] OP_ABS   = 6'd20;
  localparam logic [OP_W-1:0] OP_MIN   = 6'd21;
  localparam logic [OP_W-1:0] OP_MAX   = 6'd22;
  localparam logic [OP_W-1:0] OP_MINU  = 6'd23;
  localparam logic [OP_W-1:0] OP_MAXU  = 6'd24;
  localparam logic [OP_W-1:0] OP_PASSA = 6'd25;
  localparam logic [OP_W-1:0] OP_PASSB = 6'd26;
  localparam logic [OP_W-1:0] OP_CLZ   = 6'd27;
  localparam logic [OP_W-1:0] OP_CTZ   = 6'd28;
  localparam logic [OP_W-1:0] OP_POPC  = 6'd29;
  localparam logic [OP_W-1:0] OP_EQ    = 6'd30;
  localparam logic [OP_W-1:0] OP_NE    = 6'd31;
  localparam logic [OP_W-1:0] OP_LT    = 6'd32;
  localparam logic [OP_W-1:0] OP_LTU   = 6'd33;
  localparam logic [OP_W-1:0] OP_GE    = 6'd34;
  localparam logic [OP_W-1:0] OP_LOADI = 6'd63;

  localparam int unsigned FLG_CARRY    = 0;
  localparam int unsigned FLG_OVERFLOW = 1;
  localparam int unsigned FLG_ZERO     = 2;
  localparam int unsigned FLG_NEGATIVE = 3;
  localparam int unsigned FLG_PARITY   = 4;
  localparam int unsigned FLG_MODULO   = 5;
  localparam int unsigned FLG_SIGN     = 6;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} seq_state_e;

  // Command fields that must survive into EXEC
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [RIDX_W-1:0] rd;
    logic [W-1:0]      imm;
  } cmd_lat_t;

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return op <= OP_GE;
  endfunction

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return is_alu_op(op) || (op == OP_LOADI);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x W register file: two async read ports, two write ports, sync clear.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RIDX_W-1:0] ra0_i,
  input  logic [RIDX_W-1:0] ra1_i,
  output logic [W-1:0]      rdata0_o,
  output logic [W-1:0]      rdata1_o,
  input  logic              we0_i,
  input  logic [RIDX_W-1:0] wa0_i,
  input  logic [W-1:0]      wd0_i,
  input  logic              we1_i,
  input  logic [RIDX_W-1:0] wa1_i,
  input  logic [W-1:0]      wd1_i
);

  logic [W-1:0] mem_q [NREGS];

  // Port 0 is written last so it wins an address clash
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      if (we1_i) mem_q[wa1_i] <= wd1_i;
      if (we0_i) mem_q[wa0_i] <= wd0_i;
    end
  end

  assign rdata0_o = mem_q[ra0_i];
  assign rdata1_o = mem_q[ra1_i];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front end for the combinational ALU: fetch, execute, write back, respond.
module alu_cmd_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [RIDX_W-1:0] cmd_rd,
  input  logic [RIDX_W-1:0] cmd_rs1,
  input  logic [RIDX_W-1:0] cmd_rs2,
  input  logic [W-1:0]      cmd_imm,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [W-1:0]      alu_result,
  input  logic [W-1:0]      alu_upper,
  input  logic [FLG_W-1:0]  alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W-1:0]      rsp_result,
  output logic [FLG_W-1:0]  rsp_flags,
  output logic              rsp_err
);

  seq_state_e        state_q;
  cmd_lat_t          cmd_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [W-1:0]      rsp_result_q;
  logic [FLG_W-1:0]  rsp_flags_q;
  logic              rsp_err_q;
  logic [W-1:0]      alu_a_q;
  logic [W-1:0]      alu_b_q;
  logic [OP_W-1:0]   alu_sel_q;

  logic [W-1:0]      rf_rdata0;
  logic [W-1:0]      rf_rdata1;
  logic              in_exec;
  logic              op_loadi;
  logic              op_alu;
  logic              wb0_en;
  logic              wb1_en;
  logic [W-1:0]      wb0_data;
  logic [RIDX_W-1:0] wb1_addr;

  assign in_exec  = (state_q == EXEC);
  assign op_loadi = (cmd_q.op == OP_LOADI);
  assign op_alu   = is_alu_op(cmd_q.op);
  assign wb0_en   = in_exec && is_legal_op(cmd_q.op);
  assign wb0_data = op_loadi ? cmd_q.imm : alu_result;
  assign wb1_en   = in_exec && (cmd_q.op == OP_MUL);
  assign wb1_addr = cmd_q.rd + RIDX_W'(1);

  alu_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .ra0_i    (cmd_rs1),
    .ra1_i    (cmd_rs2),
    .rdata0_o (rf_rdata0),
    .rdata1_o (rf_rdata1),
    .we0_i    (wb0_en),
    .wa0_i    (cmd_q.rd),
    .wd0_i    (wb0_data),
    .we1_i    (wb1_en),
    .wa1_i    (wb1_addr),
    .wd1_i    (alu_upper)
  );

  // Sequencing FSM; operand registers double as the ALU drive and are zero outside EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_q       <= '{op: cmd_op, rd: cmd_rd, imm: cmd_imm};
            alu_a_q     <= rf_rdata0;
            alu_b_q     <= rf_rdata1;
            alu_sel_q   <= cmd_op;
            cmd_ready_q <= 1'b0;
            state_q     <= EXEC;
          end
        end
        EXEC: begin
          if (op_loadi) begin
            rsp_result_q <= cmd_q.imm;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b0;
          end else if (op_alu) begin
            rsp_result_q <= alu_result;
            rsp_flags_q  <= alu_flags;
            rsp_err_q    <= 1'b0;
          end else begin
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
            rsp_err_q    <= 1'b1;
          end
          rsp_valid_q <= 1'b1;
          alu_a_q     <= '0;
          alu_b_q     <= '0;
          alu_sel_q   <= '0;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;

endmodule
